// File: rtl/reg_file_write_arbiter_if.sv
// Write-request bundle between the register file's requesters and the
// write arbiter: per-requester valid/ready plus target id, data and mask.
interface reg_file_write_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_WIDTH       = 4,
    parameter int REGISTER_WIDTH = 32
);
    logic [NUM_REQUESTERS-1:0]                     req_valid;
    logic [NUM_REQUESTERS-1:0]                     req_ready;
    logic [NUM_REQUESTERS-1:0][ID_WIDTH-1:0]       req_id;
    logic [NUM_REQUESTERS-1:0][REGISTER_WIDTH-1:0] req_data;
    logic [NUM_REQUESTERS-1:0][REGISTER_WIDTH-1:0] req_mask;

    modport master (
        output req_valid, req_id, req_data, req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_id, req_data, req_mask,
        output req_ready
    );
endinterface

// File: rtl/reg_file_write_arbiter.sv
// Shares the register file's direct write port: one grant per cycle,
// masked read-modify-write with forwarding from the in-flight write.
module reg_file_write_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int NUM_REGISTERS  = 16,
    parameter int REGISTER_WIDTH = 32,
    parameter int ID_WIDTH       = $clog2(NUM_REGISTERS),
    parameter int BUS_PRIORITY   = 1
) (
    input  logic clk,
    input  logic rst_n,
    reg_file_write_arbiter_if.slave req,
    input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] i_reg_read_data,
    output logic [NUM_REGISTERS-1:0]                     o_write_req,
    output logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] o_write_data,
    output logic                                         o_id_error,
    output logic                                         o_busy
);
    localparam int PW = $clog2(NUM_REQUESTERS);

    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             rr_nxt;
    logic [PW-1:0]             gnt_idx;
    logic                      found;
    logic                      rr_win;
    logic                      accept;
    int                        k;
    int                        nk;

    logic [ID_WIDTH-1:0]       sel_id;
    logic [REGISTER_WIDTH-1:0] sel_data;
    logic [REGISTER_WIDTH-1:0] sel_mask;
    logic [REGISTER_WIDTH-1:0] rd_val;
    logic [REGISTER_WIDTH-1:0] base;
    logic [REGISTER_WIDTH-1:0] merged;
    logic                      in_range;

    logic                      stg_valid;
    logic [ID_WIDTH-1:0]       stg_id;
    logic [REGISTER_WIDTH-1:0] stg_data;

    // Index 0 is excluded from the rotation when the bus has priority.
    always_comb begin
        found   = 1'b0;
        rr_win  = 1'b0;
        gnt_idx = '0;
        k       = 0;
        if (BUS_PRIORITY != 0 && req.req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int o = 0; o < NUM_REQUESTERS; o++) begin
                k = int'(rr_ptr) + o;
                if (k >= NUM_REQUESTERS) k = k - NUM_REQUESTERS;
                if (!found && req.req_valid[PW'(k)] &&
                    !(BUS_PRIORITY != 0 && k == 0)) begin
                    found   = 1'b1;
                    rr_win  = 1'b1;
                    gnt_idx = PW'(k);
                end
            end
        end
    end

    always_comb begin
        nk = int'(gnt_idx) + 1;
        if (nk >= NUM_REQUESTERS) nk = 0;
        if (BUS_PRIORITY != 0 && nk == 0) nk = 1;
        rr_nxt = PW'(nk);
    end

    assign accept        = found && rst_n;
    assign req.req_ready = accept ? (NUM_REQUESTERS'(1) << gnt_idx) : '0;

    assign sel_id   = req.req_id[gnt_idx];
    assign sel_data = req.req_data[gnt_idx];
    assign sel_mask = req.req_mask[gnt_idx];

    always_comb begin
        in_range = 1'b0;
        rd_val   = '0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (sel_id == ID_WIDTH'(r)) begin
                in_range = 1'b1;
                rd_val   = i_reg_read_data[r];
            end
        end
    end

    // The register file lags one cycle behind the stage, so forward it.
    assign base   = (stg_valid && stg_id == sel_id) ? stg_data : rd_val;
    assign merged = (base & ~sel_mask) | (sel_data & sel_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid  <= 1'b0;
            stg_id     <= '0;
            stg_data   <= '0;
            rr_ptr     <= '0;
            o_id_error <= 1'b0;
        end else begin
            stg_valid  <= accept && in_range;
            o_id_error <= accept && !in_range;
            if (accept) begin
                stg_id   <= sel_id;
                stg_data <= merged;
            end
            if (accept && rr_win) rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        o_write_req  = '0;
        o_write_data = '0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (stg_valid && stg_id == ID_WIDTH'(r)) begin
                o_write_req[r]  = 1'b1;
                o_write_data[r] = stg_data;
            end
        end
    end

    assign o_busy = stg_valid;
endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench: one round-robin instance and one bus-priority instance,
// each backed by a small register file model.
module tb_reg_file_write_arbiter;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    reg_file_write_arbiter_if #(.NUM_REQUESTERS(4), .ID_WIDTH(5),
        .REGISTER_WIDTH(32)) ia ();
    reg_file_write_arbiter_if #(.NUM_REQUESTERS(4), .ID_WIDTH(5),
        .REGISTER_WIDTH(32)) ib ();

    logic [15:0][31:0] rd_a, wd_a, rd_b, wd_b;
    logic [15:0]       wr_a, wr_b;
    logic              err_a, err_b, busy_a, busy_b;

    reg_file_write_arbiter #(
        .NUM_REQUESTERS(4), .NUM_REGISTERS(16), .REGISTER_WIDTH(32),
        .ID_WIDTH(5), .BUS_PRIORITY(0)
    ) u_rr (
        .clk(clk), .rst_n(rst_n), .req(ia),
        .i_reg_read_data(rd_a), .o_write_req(wr_a),
        .o_write_data(wd_a), .o_id_error(err_a), .o_busy(busy_a)
    );

    reg_file_write_arbiter #(
        .NUM_REQUESTERS(4), .NUM_REGISTERS(16), .REGISTER_WIDTH(32),
        .ID_WIDTH(5), .BUS_PRIORITY(1)
    ) u_bp (
        .clk(clk), .rst_n(rst_n), .req(ib),
        .i_reg_read_data(rd_b), .o_write_req(wr_b),
        .o_write_data(wd_b), .o_id_error(err_b), .o_busy(busy_b)
    );

    // Register file models.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (wr_a[r]) rd_a[r] <= wd_a[r];
                if (wr_b[r]) rd_b[r] <= wd_b[r];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ia.req_valid = '0; ia.req_id = '0;
        ia.req_data = '0;  ia.req_mask = '0;
        ib.req_valid = '0; ib.req_id = '0;
        ib.req_data = '0;  ib.req_mask = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy_a", 64'(busy_a), 0);
        chk("rst_wr_a", 64'(wr_a), 0);
        chk("rst_err_b", 64'(err_b), 0);
        chk("rst_busy_b", 64'(busy_b), 0);

        // Requests valid, then reset asserted mid-cycle
        ia.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ia.req_id[i]   = 5'(i);
            ia.req_data[i] = 32'h100 + 32'(i);
            ia.req_mask[i] = '1;
        end
        ib.req_valid   = 4'h1;
        ib.req_id[0]   = 5'd7;
        ib.req_data[0] = 32'hDEAD;
        ib.req_mask[0] = '1;
        @(posedge clk); #1;
        chk("pre_rst_busy_a", 64'(busy_a), 1);
        chk("pre_rst_busy_b", 64'(busy_b), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy_a", 64'(busy_a), 0);
        chk("async_rst_wr_a", 64'(wr_a), 0);
        chk("async_rst_wd_a", 64'(|wd_a), 0);
        chk("async_rst_ready_a", 64'(ia.req_ready), 0);
        chk("async_rst_ready_b", 64'(ib.req_ready), 0);
        chk("async_rst_wr_b", 64'(wr_b), 0);
        ib.req_valid = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("first_grant_ptr0", 64'(ia.req_ready), 64'h1);

        // Round-robin, all four valid
        for (int c = 0; c < 8; c++) begin
            chk("rr_ready", 64'(ia.req_ready), 64'(1 << (c % 4)));
            @(posedge clk); #1;
            chk("rr_wr", 64'(wr_a), 64'(1 << (c % 4)));
            chk("rr_data", 64'(wd_a[c % 4]), 64'(32'h100 + c % 4));
            @(negedge clk);
        end
        ia.req_valid = '0;
        @(posedge clk); #1;
        chk("rr_idle_busy", 64'(busy_a), 0);
        chk("rr_idle_wr", 64'(wr_a), 0);

        // Bus priority: requesters 0 and 2 valid
        @(negedge clk);
        ib.req_valid   = 4'b0101;
        ib.req_id[0]   = 5'd1;
        ib.req_data[0] = 32'h11;
        ib.req_mask[0] = '1;
        ib.req_id[2]   = 5'd2;
        ib.req_data[2] = 32'h22;
        ib.req_mask[2] = '1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready0", 64'(ib.req_ready), 64'h1);
            @(posedge clk); #1;
            chk("bp_wr0", 64'(wr_b), 64'h0002);
            @(negedge clk);
        end
        ib.req_valid = 4'b0100;
        #1;
        chk("bp_ready2", 64'(ib.req_ready), 64'h4);
        @(posedge clk); #1;
        chk("bp_wr2", 64'(wr_b), 64'h0004);
        chk("bp_data2", 64'(wd_b[2]), 64'h22);

        // Forwarding on register 5
        @(negedge clk);
        ib.req_valid   = 4'b0010;
        ib.req_id[1]   = 5'd5;
        ib.req_data[1] = 32'h0000_00FF;
        ib.req_mask[1] = 32'h0000_00FF;
        #1;
        chk("fwd_ready1", 64'(ib.req_ready), 64'h2);
        @(posedge clk); #1;
        chk("fwd_wr1", 64'(wr_b), 64'h0020);
        chk("fwd_data1", 64'(wd_b[5]), 64'h0000_00FF);
        @(negedge clk);
        ib.req_valid   = 4'b0100;
        ib.req_id[2]   = 5'd5;
        ib.req_data[2] = 32'hAB00_0000;
        ib.req_mask[2] = 32'hFF00_0000;
        #1;
        chk("fwd_ready2", 64'(ib.req_ready), 64'h4);
        @(posedge clk); #1;
        chk("fwd_wr2", 64'(wr_b), 64'h0020);
        chk("fwd_data2", 64'(wd_b[5]), 64'hAB00_00FF);
        @(negedge clk);
        ib.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("fwd_final_reg5", 64'(rd_b[5]), 64'hAB00_00FF);

        // Out-of-range id
        @(negedge clk);
        ib.req_valid   = 4'b0010;
        ib.req_id[1]   = 5'd20;
        ib.req_data[1] = 32'hFFFF;
        ib.req_mask[1] = '1;
        #1;
        chk("err_ready", 64'(ib.req_ready), 64'h2);
        @(posedge clk); #1;
        chk("err_pulse", 64'(err_b), 1);
        chk("err_no_wr", 64'(wr_b), 0);
        chk("err_busy", 64'(busy_b), 0);
        @(negedge clk);
        ib.req_valid = '0;
        @(posedge clk); #1;
        chk("err_pulse_end", 64'(err_b), 0);

        // Mask zero on register 3
        @(negedge clk);
        ib.req_valid   = 4'b0001;
        ib.req_id[0]   = 5'd3;
        ib.req_data[0] = 32'h1234_5678;
        ib.req_mask[0] = '1;
        @(posedge clk); #1;
        chk("m0_preload", 64'(wd_b[3]), 64'h1234_5678);
        @(negedge clk);
        ib.req_data[0] = 32'hFFFF_FFFF;
        ib.req_mask[0] = '0;
        @(posedge clk); #1;
        chk("m0_fwd_wr", 64'(wr_b), 64'h0008);
        chk("m0_fwd_data", 64'(wd_b[3]), 64'h1234_5678);
        @(negedge clk);
        ib.req_valid = '0;
        repeat (2) @(negedge clk);
        ib.req_valid = 4'b0001;
        @(posedge clk); #1;
        chk("m0_wr", 64'(wr_b), 64'h0008);
        chk("m0_data", 64'(wd_b[3]), 64'h1234_5678);
        @(negedge clk);
        ib.req_valid = '0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
